memory_access: RTL and testbench
================================

// Module: memory_access
// PURPOSE
//  Pipeline stage 4 (MEM) plus MEM/WB register. Consumes EX/MEM register outputs (*_3) and runs the
//  data-cache request/wait handshake. Drives memory_stall back to fetch/decode/execute, and drives the
//  *_5 writeback and forwarding signals into execute and the register file.
// PARAMETERS
//  DATA_W  32  data width (ALU result, store data, load data)
//  ADDR_W  30  data-cache word address width (byte address bits [31:2])
//  PERF_W  32  width of optional performance counters
// PORTS
//  clk               in   1       clock, rising edge
//  rst_n             in   1       asynchronous active-low reset
//  WriteBack_3       in   1       EX/MEM register-write enable
//  Mem_3             in   2       {MemRead, MemWrite}
//  ALU_result_3      in   DATA_W  byte address for load/store; result for ALU ops
//  writedata_3       in   DATA_W  store data
//  Rd_3              in   5       destination register
//  DCACHE_ren        out  1       cache read request
//  DCACHE_wen        out  1       cache write request
//  DCACHE_addr       out  ADDR_W  word address = ALU_result_3[31:2]
//  DCACHE_wdata      out  DATA_W  = writedata_3
//  DCACHE_rdata      in   DATA_W  load data, valid while in WAIT with DCACHE_stall==0
//  DCACHE_stall      in   1       cache busy; low while in WAIT = transaction complete
//  memory_stall      out  1       freeze all upstream pipeline registers
//  WriteBack_5       out  1       MEM/WB register-write enable
//  Rd_5              out  5       MEM/WB destination register
//  writeback_data_5  out  DATA_W  MEM/WB result (load data or ALU result)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; WriteBack_5=0, Rd_5=0, writeback_data_5=0.
//    DCACHE_ren/wen=0 and memory_stall=0 while in reset. Reset mid-access abandons the access.
//  - Op decode: rd = Mem_3[1], wr = Mem_3[0] & ~Mem_3[1]. 2'b11 is executed as a read.
//  - FSM, 2 states:
//    IDLE: if rd|wr: ren=rd, wen=wr, memory_stall=1, next=WAIT. Otherwise no request, memory_stall=0.
//    WAIT: ren/wen held at same values with stable addr/wdata.
//          DCACHE_stall=1: memory_stall=1, stay in WAIT.
//          DCACHE_stall=0: memory_stall=0, load data taken this cycle, next=IDLE.
//  - Latency: minimum 2 cycles per memory op (IDLE + 1 WAIT); 1 cycle for non-memory ops.
//  - Back-to-back memory ops: after WAIT->IDLE the new *_3 op is requested in the next cycle. No idle gap.
//  - MEM/WB register updates only when memory_stall==0; it holds when memory_stall==1.
//    WriteBack_5 <= WriteBack_3; Rd_5 <= Rd_3.
//    writeback_data_5 <= rd ? DCACHE_rdata : ALU_result_3.
//  - memory_stall is combinational from state and Mem_3/DCACHE_stall. There is no path from memory_stall
//    back to Mem_3 within the same cycle.
//  - Store writes WriteBack_3 through unchanged; decode guarantees it is 0 for stores.
// CONFIGURATION
//  MEM_PERF_CNT_EN defined:
//    - adds output ports perf_access_cnt[PERF_W] and perf_stall_cnt[PERF_W].
//    - perf_access_cnt increments on each WAIT->IDLE transition.
//    - perf_stall_cnt increments each cycle memory_stall==1.
//    - both counters: async reset to 0, saturate at all-ones.
//  MEM_PERF_CNT_EN undefined: counter ports and logic are absent. No other behaviour changes.
// STRUCTURE
//  - Shared include riscv_defs.vh holds: MEM_RD_BIT=1, MEM_WR_BIT=0, state encodings S_IDLE=1'b0 and
//    S_WAIT=1'b1, and the DATA_W/ADDR_W defaults used by all stages.
//  - One sub-module, mem_perf_counter (saturating PERF_W counter with enable), instantiated twice and
//    only under MEM_PERF_CNT_EN.
// TESTING
//  1. ALU op: Mem_3=00, WriteBack_3=1, Rd_3=5, ALU_result_3=0x1234 -> no request, memory_stall=0;
//     next cycle WriteBack_5=1, Rd_5=5, writeback_data_5=0x1234.
//  2. Load with 3-cycle miss: Mem_3=10, ALU_result_3=0x100, DCACHE_stall=1 for 2 WAIT cycles, then 0
//     with rdata=0xDEADBEEF -> DCACHE_addr=0x40; ren high 4 cycles; memory_stall high 3 cycles;
//     writeback_data_5=0xDEADBEEF after the release edge.
//  3. Store: Mem_3=01, writedata_3=0xA5A5A5A5, ALU_result_3=0x8, DCACHE_stall=0 in first WAIT ->
//     wen=1 for 2 cycles, DCACHE_wdata=0xA5A5A5A5, DCACHE_addr=0x2, memory_stall=1 for exactly 1 cycle.
//  4. Back-to-back load then store, both with immediate completion ->
//     IDLE,WAIT,IDLE,WAIT; 4 cycles total; ren then wen; no idle gap.
//  5. rst_n pulled low in WAIT with DCACHE_stall=1 -> ren/wen/memory_stall and all *_5 outputs are 0
//     immediately (asynchronously); state=IDLE after release.
//  6. MEM_PERF_CNT_EN defined, replay test 2 -> perf_access_cnt=1, perf_stall_cnt=3.

Source files
------------

// File: rtl/memory_access_pkg.sv
// -----------------------------------------------------------------------------
// memory_access_pkg
//   Definitions shared by the MEM stage and its helpers.
//   - Bit positions of the {MemRead, MemWrite} control pair.
//   - MEM-stage FSM state encoding.
//   - Default data and cache-address widths.
//   - Helpers that decode the two-bit memory opcode.
// -----------------------------------------------------------------------------
package memory_access_pkg;

    localparam int MEM_RD_BIT = 1;
    localparam int MEM_WR_BIT = 0;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 30;
    localparam int PERF_W_DEF = 32;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } mem_state_e;

    // MemRead has priority, so 2'b11 behaves as a plain load.
    function automatic logic op_is_read(input logic [1:0] mem);
        return mem[MEM_RD_BIT];
    endfunction

    function automatic logic op_is_write(input logic [1:0] mem);
        return mem[MEM_WR_BIT] & ~mem[MEM_RD_BIT];
    endfunction

endpackage

// File: rtl/mem_perf_counter.sv
// -----------------------------------------------------------------------------
// mem_perf_counter
//   Saturating event counter used by the MEM stage performance monitors.
//   The module exists only when MEM_PERF_CNT_EN is defined.
//
//   Ports
//     clk    in   1       clock, rising edge
//     rst_n  in   1       asynchronous active-low reset, clears the count
//     en_i   in   1       count one event this cycle
//     cnt_o  out  PERF_W  current count; sticks at all-ones
// -----------------------------------------------------------------------------
`ifdef MEM_PERF_CNT_EN
module mem_perf_counter #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    output logic [PERF_W-1:0] cnt_o
);

    logic [PERF_W-1:0] cnt_q;
    logic [PERF_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {PERF_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/memory_access.sv
// -----------------------------------------------------------------------------
// memory_access
//   MEM pipeline stage plus the MEM/WB register. It takes the EX/MEM outputs
//   (*_3) and runs the data-cache request/wait handshake. It stalls the
//   upstream stages while an access is outstanding. It also produces the
//   writeback/forwarding signals (*_5).
//
//   Optional feature macro: MEM_PERF_CNT_EN
//     Adds perf_access_cnt (completed accesses) and perf_stall_cnt (stalled
//     cycles). Both are saturating counters.
//
//   Ports
//     clk               in   1       clock, rising edge
//     rst_n             in   1       asynchronous active-low reset
//     WriteBack_3       in   1       EX/MEM register-write enable
//     Mem_3             in   2       {MemRead, MemWrite}
//     ALU_result_3      in   DATA_W  byte address (ld/st) or ALU result
//     writedata_3       in   DATA_W  store data
//     Rd_3              in   5       destination register
//     DCACHE_ren        out  1       cache read request
//     DCACHE_wen        out  1       cache write request
//     DCACHE_addr       out  ADDR_W  word address
//     DCACHE_wdata      out  DATA_W  store data to cache
//     DCACHE_rdata      in   DATA_W  load data
//     DCACHE_stall      in   1       cache busy
//     memory_stall      out  1       freeze upstream pipeline registers
//     WriteBack_5       out  1       MEM/WB register-write enable
//     Rd_5              out  5       MEM/WB destination register
//     writeback_data_5  out  DATA_W  MEM/WB result
//     perf_access_cnt   out  PERF_W  (MEM_PERF_CNT_EN only)
//     perf_stall_cnt    out  PERF_W  (MEM_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module memory_access
    import memory_access_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int PERF_W = PERF_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              WriteBack_3,
    input  logic [1:0]        Mem_3,
    input  logic [DATA_W-1:0] ALU_result_3,
    input  logic [DATA_W-1:0] writedata_3,
    input  logic [4:0]        Rd_3,
    output logic              DCACHE_ren,
    output logic              DCACHE_wen,
    output logic [ADDR_W-1:0] DCACHE_addr,
    output logic [DATA_W-1:0] DCACHE_wdata,
    input  logic [DATA_W-1:0] DCACHE_rdata,
    input  logic              DCACHE_stall,
    output logic              memory_stall,
`ifdef MEM_PERF_CNT_EN
    output logic [PERF_W-1:0] perf_access_cnt,
    output logic [PERF_W-1:0] perf_stall_cnt,
`endif
    output logic              WriteBack_5,
    output logic [4:0]        Rd_5,
    output logic [DATA_W-1:0] writeback_data_5
);

    mem_state_e        state_q;
    mem_state_e        state_d;

    logic              wb_q;
    logic [4:0]        rd_q;
    logic [DATA_W-1:0] data_q;

    logic              op_rd;
    logic              op_wr;
    logic              access_done;
    logic              unused_addr_bits;

    assign op_rd = op_is_read(Mem_3);
    assign op_wr = op_is_write(Mem_3);

    // The two low byte-address bits are not used by the word-addressed cache.
    assign unused_addr_bits = ^ALU_result_3[1:0];

    // Upstream is frozen during WAIT, so Mem_3 and the address stay stable.
    // The requests can therefore follow the *_3 inputs directly in both
    // states. Gating with rst_n forces the requests low while reset is
    // asserted, even before the clock runs.
    assign DCACHE_ren   = rst_n & op_rd;
    assign DCACHE_wen   = rst_n & op_wr;
    assign DCACHE_addr  = ALU_result_3[ADDR_W+1:2];
    assign DCACHE_wdata = writedata_3;

    assign access_done = (state_q == S_WAIT) && !DCACHE_stall;

    // Stall is combinational. An op is stalled in its IDLE cycle. In WAIT it
    // stalls for as long as the cache reports busy.
    always_comb begin
        memory_stall = 1'b0;
        state_d      = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (op_rd || op_wr) begin
                    memory_stall = 1'b1;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                memory_stall = DCACHE_stall;
                if (!DCACHE_stall) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (!rst_n) begin
            memory_stall = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // MEM/WB register: it holds while the stage is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q   <= 1'b0;
            rd_q   <= 5'd0;
            data_q <= '0;
        end else if (!memory_stall) begin
            wb_q   <= WriteBack_3;
            rd_q   <= Rd_3;
            data_q <= op_rd ? DCACHE_rdata : ALU_result_3;
        end
    end

    assign WriteBack_5      = wb_q;
    assign Rd_5             = rd_q;
    assign writeback_data_5 = data_q;

`ifdef MEM_PERF_CNT_EN
    mem_perf_counter #(
        .PERF_W (PERF_W)
    ) u_access_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (access_done),
        .cnt_o (perf_access_cnt)
    );

    mem_perf_counter #(
        .PERF_W (PERF_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (memory_stall),
        .cnt_o (perf_stall_cnt)
    );
`else
    logic unused_access_done;
    assign unused_access_done = access_done;
`endif

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

    logic        clk;
    logic        rst_n;
    logic        WriteBack_3;
    logic [1:0]  Mem_3;
    logic [31:0] ALU_result_3;
    logic [31:0] writedata_3;
    logic [4:0]  Rd_3;
    logic        DCACHE_ren;
    logic        DCACHE_wen;
    logic [29:0] DCACHE_addr;
    logic [31:0] DCACHE_wdata;
    logic [31:0] DCACHE_rdata;
    logic        DCACHE_stall;
    logic        memory_stall;
    logic        WriteBack_5;
    logic [4:0]  Rd_5;
    logic [31:0] writeback_data_5;
`ifdef MEM_PERF_CNT_EN
    logic [31:0] perf_access_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int tests;
    int fails;
    int ren_cyc;
    int wen_cyc;
    int stall_cyc;

    memory_access dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .WriteBack_3      (WriteBack_3),
        .Mem_3            (Mem_3),
        .ALU_result_3     (ALU_result_3),
        .writedata_3      (writedata_3),
        .Rd_3             (Rd_3),
        .DCACHE_ren       (DCACHE_ren),
        .DCACHE_wen       (DCACHE_wen),
        .DCACHE_addr      (DCACHE_addr),
        .DCACHE_wdata     (DCACHE_wdata),
        .DCACHE_rdata     (DCACHE_rdata),
        .DCACHE_stall     (DCACHE_stall),
        .memory_stall     (memory_stall),
`ifdef MEM_PERF_CNT_EN
        .perf_access_cnt  (perf_access_cnt),
        .perf_stall_cnt   (perf_stall_cnt),
`endif
        .WriteBack_5      (WriteBack_5),
        .Rd_5             (Rd_5),
        .writeback_data_5 (writeback_data_5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n        = 1'b0;
        WriteBack_3  = 1'b0;
        Mem_3        = 2'b10;
        ALU_result_3 = 32'h0;
        writedata_3  = 32'h0;
        Rd_3         = 5'd0;
        DCACHE_rdata = 32'h0;
        DCACHE_stall = 1'b0;

        // Reset state: a pending load must not raise requests during reset.
        #3;
        check("rst_ren", DCACHE_ren, 1'b0);
        check("rst_stall", memory_stall, 1'b0);
        check("rst_wb5", WriteBack_5, 1'b0);
        check("rst_rd5", Rd_5, 5'd0);
        check("rst_data5", writeback_data_5, 32'h0);
        Mem_3 = 2'b00;
        #9 rst_n = 1'b1;

        // Test 1: ALU op passes straight through in one cycle.
        tick();
        Mem_3 = 2'b00; WriteBack_3 = 1'b1; Rd_3 = 5'd5; ALU_result_3 = 32'h1234;
        #1;
        check("alu_ren", DCACHE_ren, 1'b0);
        check("alu_wen", DCACHE_wen, 1'b0);
        check("alu_stall", memory_stall, 1'b0);
        tick();
        check("alu_wb5", WriteBack_5, 1'b1);
        check("alu_rd5", Rd_5, 5'd5);
        check("alu_data5", writeback_data_5, 32'h1234);

        // Test 2: load that stays busy for two WAIT cycles.
        Mem_3 = 2'b10; ALU_result_3 = 32'h100; Rd_3 = 5'd7; WriteBack_3 = 1'b1;
        DCACHE_stall = 1'b1; DCACHE_rdata = 32'h0;
        ren_cyc = 0; stall_cyc = 0;
        #1;
        check("ld_addr", DCACHE_addr, 30'h40);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                DCACHE_stall = 1'b0;
                DCACHE_rdata = 32'hDEADBEEF;
            end
            #1;
            ren_cyc   += DCACHE_ren;
            stall_cyc += memory_stall;
            if (c == 2) check("ld_hold_data5", writeback_data_5, 32'h1234);
            tick();
        end
        Mem_3 = 2'b00; DCACHE_rdata = 32'h0;
        check("ld_ren_cycles", ren_cyc, 4);
        check("ld_stall_cycles", stall_cyc, 3);
        check("ld_data5", writeback_data_5, 32'hDEADBEEF);
        check("ld_rd5", Rd_5, 5'd7);
`ifdef MEM_PERF_CNT_EN
        check("perf_access", perf_access_cnt, 32'd1);
        check("perf_stall", perf_stall_cnt, 32'd3);
`endif
        #1;
        check("ld_idle_ren", DCACHE_ren, 1'b0);
        check("ld_idle_stall", memory_stall, 1'b0);

        // Test 3: store that completes in its first WAIT cycle.
        tick();
        Mem_3 = 2'b01; writedata_3 = 32'hA5A5A5A5; ALU_result_3 = 32'h8;
        WriteBack_3 = 1'b0; Rd_3 = 5'd0; DCACHE_stall = 1'b0;
        wen_cyc = 0; stall_cyc = 0;
        #1;
        check("st_addr", DCACHE_addr, 30'h2);
        check("st_wdata", DCACHE_wdata, 32'hA5A5A5A5);
        check("st_ren", DCACHE_ren, 1'b0);
        for (int c = 0; c < 2; c++) begin
            #1;
            wen_cyc   += DCACHE_wen;
            stall_cyc += memory_stall;
            tick();
        end
        Mem_3 = 2'b00;
        check("st_wen_cycles", wen_cyc, 2);
        check("st_stall_cycles", stall_cyc, 1);
        check("st_wb5", WriteBack_5, 1'b0);
        #1;
        check("st_idle_wen", DCACHE_wen, 1'b0);

        // Test 4: load then store back to back, both complete immediately.
        tick();
        Mem_3 = 2'b10; ALU_result_3 = 32'h10; WriteBack_3 = 1'b1; Rd_3 = 5'd3;
        DCACHE_rdata = 32'h11112222; DCACHE_stall = 1'b0;
        #1;
        check("b2b_c0_ren", DCACHE_ren, 1'b1);
        check("b2b_c0_stall", memory_stall, 1'b1);
        tick();
        check("b2b_c1_ren", DCACHE_ren, 1'b1);
        check("b2b_c1_stall", memory_stall, 1'b0);
        tick();
        check("b2b_ld_data5", writeback_data_5, 32'h11112222);
        check("b2b_ld_rd5", Rd_5, 5'd3);
        Mem_3 = 2'b01; ALU_result_3 = 32'h20; WriteBack_3 = 1'b0; Rd_3 = 5'd0;
        #1;
        check("b2b_c2_wen", DCACHE_wen, 1'b1);
        check("b2b_c2_ren", DCACHE_ren, 1'b0);
        check("b2b_c2_stall", memory_stall, 1'b1);
        tick();
        check("b2b_c3_wen", DCACHE_wen, 1'b1);
        check("b2b_c3_stall", memory_stall, 1'b0);
        tick();
        Mem_3 = 2'b00;
        check("b2b_st_data5", writeback_data_5, 32'h20);
        check("b2b_st_wb5", WriteBack_5, 1'b0);

        // 2'b11 is executed as a read.
        Mem_3 = 2'b11; ALU_result_3 = 32'hC; DCACHE_rdata = 32'h0BADF00D;
        WriteBack_3 = 1'b1; Rd_3 = 5'd12;
        #1;
        check("rw_ren", DCACHE_ren, 1'b1);
        check("rw_wen", DCACHE_wen, 1'b0);
        tick();
        tick();
        Mem_3 = 2'b00;
        check("rw_data5", writeback_data_5, 32'h0BADF00D);

        // Test 5: reset in the middle of a busy access.
        Mem_3 = 2'b00; WriteBack_3 = 1'b1; Rd_3 = 5'd9; ALU_result_3 = 32'h55;
        tick();
        check("pre_rst_rd5", Rd_5, 5'd9);
        Mem_3 = 2'b10; ALU_result_3 = 32'h44; DCACHE_stall = 1'b1;
        tick();
        check("wait_stall", memory_stall, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ren", DCACHE_ren, 1'b0);
        check("arst_stall", memory_stall, 1'b0);
        check("arst_wb5", WriteBack_5, 1'b0);
        check("arst_rd5", Rd_5, 5'd0);
        check("arst_data5", writeback_data_5, 32'h0);
        Mem_3 = 2'b00;
        #1 rst_n = 1'b1;
        tick();
        // Still busy cache: a WAIT state would keep the stall raised.
        check("post_rst_stall", memory_stall, 1'b0);
        check("post_rst_ren", DCACHE_ren, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
